// File: rtl/pre_if_pc_gen.sv
// ---------------------------------------------------------------------------
// pre_if_pc_gen
//
// Program-counter generator for the PRE_IF stage. Holds the fetch PC, drives
// it to the ITLB as virt_iaddr, and registers one fetch packet per cycle into
// the IF stage from the ITLB translation result.
//
// Redirect handling:
//   - exception/ERET redirects always win and act as a flush, even under an
//     IF stall;
//   - a branch redirect that arrives while IF is stalled is parked in a
//     pending register (PEND) and applied once the stall clears;
//   - after issuing a packet that carries a fetch exception, sequential fetch
//     stops (HALT) until an exception redirect arrives.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   exc_redirect_valid  exception/ERET redirect request (highest priority)
//   exc_redirect_pc     exception/ERET target
//   br_redirect_valid   branch/jump redirect request from EX
//   br_redirect_pc      branch target
//   pc_stall            IF stage cannot accept a packet this cycle
//   tlb_stall           ITLB lookup still in progress
//   tlb_except_type     ITLB fault: 00 none, 01 refill, 10 invalid
//   phys_iaddr          translated address of virt_iaddr
//   is_cached           cacheability of phys_iaddr
//   virt_iaddr          current fetch PC (to ITLB)
//   if_valid            IF packet valid
//   if_pc               virtual PC of the packet
//   if_paddr            physical address of the packet
//   if_cached           packet cacheable
//   if_exc              {adel, tlb_except_type}; 000 = no exception
// ---------------------------------------------------------------------------
module pre_if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_redirect_valid,
  input  logic [31:0] exc_redirect_pc,
  input  logic        br_redirect_valid,
  input  logic [31:0] br_redirect_pc,
  input  logic        pc_stall,
  input  logic        tlb_stall,
  input  logic [1:0]  tlb_except_type,
  input  logic [31:0] phys_iaddr,
  input  logic        is_cached,
  output logic [31:0] virt_iaddr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_paddr,
  output logic        if_cached,
  output logic [2:0]  if_exc
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_paddr_q, if_paddr_d;
  logic        if_cached_q, if_cached_d;
  logic [2:0]  if_exc_q, if_exc_d;

  logic        adel;
  logic        redirect;
  logic        fire;
  logic        exc_pkt;
  logic [1:0]  tlb_exc_eff;

  // A misaligned PC faults on its own; the ITLB response for it is
  // meaningless, so its stall and fault type are masked out.
  assign adel        = (pc_q[1:0] != 2'b00);
  assign tlb_exc_eff = adel ? 2'b00 : tlb_except_type;

  // Any redirect that takes effect this cycle suppresses packet issue.
  assign redirect = exc_redirect_valid | br_redirect_valid |
                    ((state_q == PEND) & ~pc_stall);

  assign fire    = (state_q != HALT) & ~pc_stall & (adel | ~tlb_stall) & ~redirect;
  assign exc_pkt = fire & (adel | (tlb_except_type != 2'b00));

  // Next-state selection in strict priority order; everything holds by
  // default so stalled cycles need no explicit branch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_paddr_d  = if_paddr_q;
    if_cached_d = if_cached_q;
    if_exc_d    = if_exc_q;

    if (exc_redirect_valid) begin
      pc_d       = exc_redirect_pc;
      state_d    = RUN;
      pend_pc_d  = '0;
      if_valid_d = 1'b0;
    end else if (br_redirect_valid && pc_stall) begin
      // Park the target; a newer branch simply overwrites an older one.
      pend_pc_d = br_redirect_pc;
      state_d   = PEND;
    end else if (br_redirect_valid) begin
      pc_d       = br_redirect_pc;
      state_d    = RUN;
      if_valid_d = 1'b0;
    end else if ((state_q == PEND) && !pc_stall) begin
      pc_d       = pend_pc_q;
      state_d    = RUN;
      if_valid_d = 1'b0;
    end else if (fire) begin
      if_valid_d  = 1'b1;
      if_pc_d     = pc_q;
      if_paddr_d  = phys_iaddr;
      if_cached_d = is_cached;
      if_exc_d    = {adel, tlb_exc_eff};
      if (exc_pkt) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end else if (pc_stall) begin
      // IF register and PC hold.
    end else begin
      // ITLB miss in progress or halted: issue a bubble.
      if_valid_d = 1'b0;
    end
  end

  // State and packet registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_paddr_q  <= '0;
      if_cached_q <= 1'b0;
      if_exc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_paddr_q  <= if_paddr_d;
      if_cached_q <= if_cached_d;
      if_exc_q    <= if_exc_d;
    end
  end

  assign virt_iaddr = pc_q;
  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_paddr   = if_paddr_q;
  assign if_cached  = if_cached_q;
  assign if_exc     = if_exc_q;

endmodule

// File: tb/tb_pre_if_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pre_if_pc_gen
//
// Directed bench for pre_if_pc_gen. The ITLB is modelled as a fixed offset
// translation (phys = virt - A000_0000) with kseg1-style addresses
// (top bits 101) uncached. Expected outputs are pushed to a scoreboard queue
// as each step is driven and popped/compared after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pre_if_pc_gen;

  logic        clk;
  logic        rst;
  logic        exc_redirect_valid;
  logic [31:0] exc_redirect_pc;
  logic        br_redirect_valid;
  logic [31:0] br_redirect_pc;
  logic        pc_stall;
  logic        tlb_stall;
  logic [1:0]  tlb_except_type;
  logic [31:0] phys_iaddr;
  logic        is_cached;
  logic [31:0] virt_iaddr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_paddr;
  logic        if_cached;
  logic [2:0]  if_exc;

  typedef struct {
    string       tag;
    logic [31:0] virt;
    logic        chkPkt;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] paddr;
    logic        cached;
    logic [2:0]  exc;
  } expT;

  expT sb[$];
  int  errCount   = 0;
  int  checkCount = 0;

  pre_if_pc_gen dut (
    .clk                (clk),
    .rst                (rst),
    .exc_redirect_valid (exc_redirect_valid),
    .exc_redirect_pc    (exc_redirect_pc),
    .br_redirect_valid  (br_redirect_valid),
    .br_redirect_pc     (br_redirect_pc),
    .pc_stall           (pc_stall),
    .tlb_stall          (tlb_stall),
    .tlb_except_type    (tlb_except_type),
    .phys_iaddr         (phys_iaddr),
    .is_cached          (is_cached),
    .virt_iaddr         (virt_iaddr),
    .if_valid           (if_valid),
    .if_pc              (if_pc),
    .if_paddr           (if_paddr),
    .if_cached          (if_cached),
    .if_exc             (if_exc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple ITLB: fixed offset translation, kseg1 region uncached.
  assign phys_iaddr = virt_iaddr - 32'hA000_0000;
  assign is_cached  = (virt_iaddr[31:29] != 3'b101);

  // Drives every input for the next clock edge.
  task automatic applyStimulus(input logic rstV, input logic excV, input logic [31:0] excPc,
                               input logic brV, input logic [31:0] brPc, input logic pcStallV,
                               input logic tlbStallV, input logic [1:0] tlbExcV);
    rst                = rstV;
    exc_redirect_valid = excV;
    exc_redirect_pc    = excPc;
    br_redirect_valid  = brV;
    br_redirect_pc     = brPc;
    pc_stall           = pcStallV;
    tlb_stall          = tlbStallV;
    tlb_except_type    = tlbExcV;
  endtask

  // Expect only the fetch PC and the packet valid bit after the next edge.
  task automatic expectVv(input string tag, input logic [31:0] virt, input logic valid);
    expT e;
    e.tag = tag; e.virt = virt; e.chkPkt = 1'b0; e.valid = valid;
    e.pc = '0; e.paddr = '0; e.cached = 1'b0; e.exc = '0;
    sb.push_back(e);
  endtask

  // Expect the fetch PC and the full IF packet after the next edge.
  task automatic expectPkt(input string tag, input logic [31:0] virt, input logic valid,
                           input logic [31:0] pc, input logic [31:0] paddr,
                           input logic cached, input logic [2:0] exc);
    expT e;
    e.tag = tag; e.virt = virt; e.chkPkt = 1'b1; e.valid = valid;
    e.pc = pc; e.paddr = paddr; e.cached = cached; e.exc = exc;
    sb.push_back(e);
  endtask

  // Advance one clock and compare everything queued for that edge.
  task automatic checkOutput();
    expT e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkCount++;
      assert (virt_iaddr === e.virt) else begin
        errCount++;
        $error("[TB] FAIL %s virt_iaddr got=%h exp=%h", e.tag, virt_iaddr, e.virt);
      end
      checkCount++;
      assert (if_valid === e.valid) else begin
        errCount++;
        $error("[TB] FAIL %s if_valid got=%b exp=%b", e.tag, if_valid, e.valid);
      end
      if (e.chkPkt) begin
        checkCount++;
        assert (if_pc === e.pc) else begin
          errCount++;
          $error("[TB] FAIL %s if_pc got=%h exp=%h", e.tag, if_pc, e.pc);
        end
        checkCount++;
        assert (if_paddr === e.paddr) else begin
          errCount++;
          $error("[TB] FAIL %s if_paddr got=%h exp=%h", e.tag, if_paddr, e.paddr);
        end
        checkCount++;
        assert (if_cached === e.cached) else begin
          errCount++;
          $error("[TB] FAIL %s if_cached got=%b exp=%b", e.tag, if_cached, e.cached);
        end
        checkCount++;
        assert (if_exc === e.exc) else begin
          errCount++;
          $error("[TB] FAIL %s if_exc got=%b exp=%b", e.tag, if_exc, e.exc);
        end
      end
    end
  endtask

  initial begin
    // Reset state.
    applyStimulus(1, 0, '0, 0, '0, 0, 0, 2'b00);
    @(posedge clk);
    expectPkt("reset", 32'hBFC0_0000, 0, 32'h0, 32'h0, 0, 3'b000);
    checkOutput();

    // Free run from the reset vector.
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectPkt("run0", 32'hBFC0_0004, 1, 32'hBFC0_0000, 32'h1FC0_0000, 0, 3'b000);
    checkOutput();
    expectPkt("run1", 32'hBFC0_0008, 1, 32'hBFC0_0004, 32'h1FC0_0004, 0, 3'b000);
    checkOutput();
    expectPkt("run2", 32'hBFC0_000C, 1, 32'hBFC0_0008, 32'h1FC0_0008, 0, 3'b000);
    checkOutput();

    // ITLB stall for three cycles at 0040_0000.
    applyStimulus(0, 0, '0, 1, 32'h0040_0000, 0, 0, 2'b00);
    expectVv("br_tlb", 32'h0040_0000, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      expectVv("tlbstall", 32'h0040_0000, 0);
      checkOutput();
    end
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectPkt("tlb_done", 32'h0040_0004, 1, 32'h0040_0000, 32'h6040_0000, 1, 3'b000);
    checkOutput();

    // Branch during IF stall is buffered and applied after release.
    applyStimulus(0, 0, '0, 1, 32'h8000_1000, 1, 0, 2'b00);
    expectPkt("pend0", 32'h0040_0004, 1, 32'h0040_0000, 32'h6040_0000, 1, 3'b000);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 1, 0, 2'b00);
    expectPkt("pend1", 32'h0040_0004, 1, 32'h0040_0000, 32'h6040_0000, 1, 3'b000);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectVv("pend_apply", 32'h8000_1000, 0);
    checkOutput();
    expectPkt("pend_pkt", 32'h8000_1004, 1, 32'h8000_1000, 32'hE000_1000, 1, 3'b000);
    checkOutput();

    // Exception and branch together under stall: exception wins.
    applyStimulus(0, 1, 32'hBFC0_0380, 1, 32'h8000_2000, 1, 0, 2'b00);
    expectVv("exc_vs_br", 32'hBFC0_0380, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectPkt("exc_pkt", 32'hBFC0_0384, 1, 32'hBFC0_0380, 32'h1FC0_0380, 0, 3'b000);
    checkOutput();

    // Misaligned branch target: adel packet, ITLB response ignored, HALT.
    applyStimulus(0, 0, '0, 1, 32'h8000_0002, 0, 0, 2'b00);
    expectVv("br_adel", 32'h8000_0002, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 1, 2'b10);
    expectPkt("adel_pkt", 32'h8000_0002, 1, 32'h8000_0002, 32'hE000_0002, 1, 3'b100);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectVv("halt0", 32'h8000_0002, 0);
    checkOutput();
    expectVv("halt1", 32'h8000_0002, 0);
    checkOutput();
    applyStimulus(0, 1, 32'hBFC0_0380, 0, '0, 0, 0, 2'b00);
    expectVv("halt_exit", 32'hBFC0_0380, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectPkt("resume", 32'hBFC0_0384, 1, 32'hBFC0_0380, 32'h1FC0_0380, 0, 3'b000);
    checkOutput();

    // ITLB refill exception at 0000_4000.
    applyStimulus(0, 0, '0, 1, 32'h0000_4000, 0, 0, 2'b00);
    expectVv("br_refill", 32'h0000_4000, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b01);
    expectPkt("refill_pkt", 32'h0000_4000, 1, 32'h0000_4000, 32'h6000_4000, 1, 3'b001);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectVv("refill_halt", 32'h0000_4000, 0);
    checkOutput();

    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, '0, 0, 0, 2'b00);
    expectVv("to_top", 32'hFFFF_FFFC, 0);
    checkOutput();
    applyStimulus(0, 0, '0, 0, '0, 0, 0, 2'b00);
    expectPkt("wrap_pkt", 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h5FFF_FFFC, 1, 3'b000);
    checkOutput();
    expectPkt("after_wrap", 32'h0000_0004, 1, 32'h0000_0000, 32'h6000_0000, 1, 3'b000);
    checkOutput();

    // Reset dominates a simultaneous redirect.
    applyStimulus(1, 1, 32'h1234_5678, 1, 32'h8765_4320, 0, 0, 2'b00);
    expectPkt("rst_dom", 32'hBFC0_0000, 0, 32'h0, 32'h0, 0, 3'b000);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
